// File: rtl/genbit_decoder_pkg.sv
// Shared types and defaults for the genbit decoder: state encoding, width
// defaults and the elaboration-time index-width check.
package genbit_decoder_pkg;

    localparam int unsigned GENBIT_WIDTH = 8;
    localparam int unsigned GENBIT_IDXW  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // True when idxw is exactly log2(width) and width is a power of two >= 2.
    function automatic bit idxw_ok(input int unsigned width, input int unsigned idxw);
        return (width >= 2) && ((width & (width - 1)) == 0) && (idxw == $clog2(width));
    endfunction

endpackage

// File: rtl/genbit_decoder_lsb_index_enc.sv
// Lowest-set-bit priority encoder; also reports whether more than one bit is
// set and returns the mask with its lowest set bit cleared.
module lsb_index_enc
    import genbit_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = GENBIT_WIDTH,
    parameter int unsigned IDXW  = GENBIT_IDXW
) (
    input  logic [WIDTH-1:0] mask,
    output logic [IDXW-1:0]  index,
    output logic             any_set,
    output logic             more_than_one,
    output logic [WIDTH-1:0] cleared
);

    generate
        if (!idxw_ok(WIDTH, IDXW)) begin : g_bad_width
            $error("lsb_index_enc: IDXW must equal log2(WIDTH), WIDTH a power of two >= 2");
        end
    endgenerate

    assign cleared       = mask & (mask - WIDTH'(1));
    assign any_set       = |mask;
    assign more_than_one = |cleared;

    // NOTE: the default before the loop keeps index fully assigned on every
    // path, so no latch is inferred; scanning high-to-low leaves the lowest hit.
    always_comb begin
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/genbit_decoder.sv
// Accepts a bit mask and serially emits the index of each set bit, lowest
// first, one index per accepted output beat.
module genbit_decoder
    import genbit_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = GENBIT_WIDTH,
    parameter int unsigned IDXW  = GENBIT_IDXW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_index,
    output logic             out_last,
    output logic             out_zero
);

    generate
        if (!idxw_ok(WIDTH, IDXW)) begin : g_bad_width
            $error("genbit_decoder: IDXW must equal log2(WIDTH), WIDTH a power of two >= 2");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             zero_q, zero_d;

    logic [IDXW-1:0]  enc_index;
    logic             enc_any;
    logic             enc_multi;
    logic [WIDTH-1:0] enc_cleared;

    lsb_index_enc #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_enc (
        .mask          (mask_q),
        .index         (enc_index),
        .any_set       (enc_any),
        .more_than_one (enc_multi),
        .cleared       (enc_cleared)
    );

    // Outputs depend on registers only; gating by SCAN keeps them zero in IDLE.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SCAN);
    assign out_index = (state_q == SCAN) ? enc_index : '0;
    assign out_last  = (state_q == SCAN) && !enc_multi;
    assign out_zero  = (state_q == SCAN) && zero_q;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mask_d  = in_mask;
                    zero_d  = (in_mask == '0);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    mask_d = enc_cleared;
                    if (!enc_multi) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            zero_q  <= zero_d;
        end
    end

    // enc_any is implied by !zero_q in SCAN; kept as a consistency assertion.
    always_ff @(posedge clk) begin
        if (!reset && state_q == SCAN) begin
            assert (enc_any || zero_q || mask_q == '0)
                else $error("genbit_decoder: empty non-zero scan");
        end
    end

endmodule

// File: tb/tb_genbit_decoder.sv
// Self-checking bench for genbit_decoder: a scoreboard of expected beats is
// filled when masks are sent and drained by a monitor on handshakes.
module tb_genbit_decoder;

    localparam int WIDTH = 8;
    localparam int IDXW  = 3;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic            last;
        logic            zero;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mask;
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  out_index;
    logic             out_last;
    logic             out_zero;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    genbit_decoder #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model: one beat per set bit, lowest first; a zero mask gives one beat.
    task automatic push_expected(input logic [WIDTH-1:0] m);
        int last_bit = -1;
        for (int i = 0; i < WIDTH; i++) if (m[i]) last_bit = i;
        if (m == '0) begin
            sb.push_back('{idx: '0, last: 1'b1, zero: 1'b1});
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (m[i]) sb.push_back('{idx: IDXW'(i), last: (i == last_bit), zero: 1'b0});
            end
        end
    endtask

    // Monitor: compare each accepted output beat with the scoreboard head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", 32'(out_index), 32'hdead);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("beat_index", 32'(out_index), 32'(e.idx));
                check("beat_last",  32'(out_last),  32'(e.last));
                check("beat_zero",  32'(out_zero),  32'(e.zero));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a mask for one edge; returns one cycle after acceptance.
    task automatic send(input logic [WIDTH-1:0] m);
        check("send_in_ready", 32'(in_ready), 32'd1);
        push_expected(m);
        in_valid = 1'b1;
        in_mask  = m;
        tick();
        in_valid = 1'b0;
        in_mask  = 'x;
        check("latency_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready && !out_valid && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mask   = 'x;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_out_zero",  32'(out_zero),  32'd0);
        reset = 1'b0;
        tick();

        // 1: zero mask -> single zero beat, IDLE right after.
        out_ready = 1'b1;
        send(8'h00);
        check("t1_zero", 32'(out_zero), 32'd1);
        tick();
        check("t1_in_ready_next", 32'(in_ready), 32'd1);
        wait_idle("t1_idle");

        // 2: one-hot mask 8'h08.
        send(8'h08);
        check("t2_index", 32'(out_index), 32'd3);
        check("t2_last",  32'(out_last),  32'd1);
        wait_idle("t2_idle");

        // 3: 8'hA5 streams 0,2,5,7 back to back.
        send(8'hA5);
        for (int k = 0; k < 4; k++) begin
            check("t3_stream_valid", 32'(out_valid), 32'd1);
            check("t3_stream_last",  32'(out_last),  32'(k == 3));
            tick();
        end
        check("t3_in_ready_after", 32'(in_ready), 32'd1);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);

        // 4: backpressure holds beat 0 of 8'h81.
        out_ready = 1'b0;
        send(8'h81);
        for (int k = 0; k < 3; k++) begin
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_index", 32'(out_index), 32'd0);
            check("t4_hold_last",  32'(out_last),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        wait_idle("t4_idle");

        // 5: reset mid-scan of 8'hFF after beats 0 and 1.
        send(8'hFF);
        tick();
        tick();
        out_ready = 1'b0;
        reset     = 1'b1;
        check("t5_pending", 32'(sb.size()), 32'd6);
        tick();
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_in_ready",  32'(in_ready),  32'd1);
        sb.delete();
        reset     = 1'b0;
        out_ready = 1'b1;
        send(8'h10);
        check("t5_index", 32'(out_index), 32'd4);
        check("t5_last",  32'(out_last),  32'd1);
        wait_idle("t5_idle");

        // 6: in_valid held high during SCAN is ignored until IDLE.
        push_expected(8'h0C);
        push_expected(8'h02);
        in_valid = 1'b1;
        in_mask  = 8'h0C;
        tick();
        in_mask = 8'h02;
        check("t6_busy_ready0", 32'(in_ready), 32'd0);
        tick();
        check("t6_busy_ready1", 32'(in_ready), 32'd0);
        tick();
        check("t6_idle_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_mask  = 'x;
        check("t6_second_valid", 32'(out_valid), 32'd1);
        check("t6_second_index", 32'(out_index), 32'd1);
        wait_idle("t6_idle");

        // Extra: a few random masks with random backpressure.
        for (int n = 0; n < 6; n++) begin
            logic [WIDTH-1:0] m;
            m = WIDTH'($urandom);
            send(m);
            for (int c = 0; c < 60 && sb.size() != 0; c++) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            out_ready = 1'b1;
            wait_idle("rand_idle");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
